image_loader: RTL and testbench

Synthesizable boot-image loader sitting directly upstream of the core-plus-TCM hierarchy. It accepts a byte stream (UART receiver or bench driver) carrying a small header and a program image, and writes the image byte-by-byte into TCM through a byte write port. It holds the core in reset until the image is complete, then releases it with the boot PC taken from the header. This replaces file-based memory preload for hardware bring-up.

---
 rtl/image_loader_if.sv | 23 ++
 rtl/image_loader.sv | 164 ++++++++++++++++
 tb/tb_image_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/image_loader_if.sv
// image_loader_if: byte-stream input handshake and TCM byte write port.
// slave  = the loader (consumes the stream, drives the write port).
// master = stream source / TCM side (bench, UART receiver wrapper).
interface image_loader_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              in_valid_i;
   logic [7:0]        in_data_i;
   logic              in_ready_o;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [7:0]        wr_data_o;

   modport master (
      output in_valid_i, in_data_i,
      input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i,
      output in_ready_o, wr_en_o, wr_addr_o, wr_data_o
   );
endinterface

// File: rtl/image_loader.sv
// image_loader: boot-image loader. Parses a little-endian stream of
// {boot PC[4], length N[4], payload[N] (, checksum[1])}, writes the payload
// into TCM one byte per accept, and holds the core in reset until done.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing 8-bit sum byte
// that must match the payload sum, otherwise the load aborts).
module image_loader #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   image_loader_if.slave       bus,
   output logic                core_rst_o,
   output logic [31:0]         boot_pc_o,
   output logic                done_o,
   output logic                error_o
);

   typedef enum logic [2:0] {
      HDR_PC,
      HDR_LEN,
      PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
      CKSUM,
`endif
      DONE,
      ERROR
   } state_e;

`ifdef LOADER_CHECKSUM_EN
   localparam state_e AFTER_PAYLOAD = CKSUM;
`else
   localparam state_e AFTER_PAYLOAD = DONE;
`endif

   localparam logic [32:0]     MAX_LEN = 33'd1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [1:0]        hcnt_q;
   logic [23:0]       hdr_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   cnt_q;
   logic [31:0]       boot_pc_q;
   logic              ready_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              core_rst_q;
   logic              done_q;
   logic              error_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum_q;
`endif

   logic        accept;
   logic        hdr_last;
   logic        pay_last;
   logic [31:0] len_full;

   assign accept   = bus.in_valid_i & ready_q;
   assign hdr_last = (hcnt_q == 2'd3);
   assign pay_last = ((cnt_q + CNT_ONE) == len_q);
   // Full 32-bit length as seen while the 4th length byte is on the bus.
   assign len_full = {bus.in_data_i, hdr_q};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= HDR_PC;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR_PC: begin
            if (accept && hdr_last) state_d = HDR_LEN;
         end
         HDR_LEN: begin
            if (accept && hdr_last) begin
               if ({1'b0, len_full} > MAX_LEN) state_d = ERROR;
               else if (len_full == '0)        state_d = AFTER_PAYLOAD;
               else                            state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (accept && pay_last) state_d = AFTER_PAYLOAD;
         end
`ifdef LOADER_CHECKSUM_EN
         CKSUM: begin
            if (accept) state_d = (bus.in_data_i == sum_q) ? DONE : ERROR;
         end
`endif
         default: state_d = state_q;
      endcase
   end

   // Header collection and payload byte counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q    <= '0;
         hdr_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         boot_pc_q <= '0;
      end else if (accept) begin
         case (state_q)
            HDR_PC: begin
               // Little-endian shift-in: after 4 bytes byte k sits at [8k+7:8k].
               boot_pc_q <= {bus.in_data_i, boot_pc_q[31:8]};
               hcnt_q    <= hcnt_q + 2'd1;
            end
            HDR_LEN: begin
               hcnt_q <= hcnt_q + 2'd1;
               if (hdr_last) len_q <= len_full[ADDR_W:0];
               else          hdr_q <= {bus.in_data_i, hdr_q[23:8]};
            end
            PAYLOAD: cnt_q <= cnt_q + CNT_ONE;
            default: ;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running mod-256 sum of the payload bytes.
   always_ff @(posedge clk) begin
      if (rst)                            sum_q <= '0;
      else if (accept && state_q == PAYLOAD) sum_q <= sum_q + bus.in_data_i;
   end
`endif

   // Registered outputs: write port one cycle after accept, status one cycle after state.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         ready_q    <= (state_d != DONE) && (state_d != ERROR);
         wr_en_q    <= accept && (state_q == PAYLOAD);
         if (accept && (state_q == PAYLOAD)) begin
            wr_addr_q <= cnt_q[ADDR_W-1:0];
            wr_data_q <= bus.in_data_i;
         end
         core_rst_q <= (state_q != DONE);
         done_q     <= (state_q == DONE);
         error_q    <= (state_q == ERROR);
      end
   end

   assign bus.in_ready_o = ready_q;
   assign bus.wr_en_o    = wr_en_q;
   assign bus.wr_addr_o  = wr_addr_q;
   assign bus.wr_data_o  = wr_data_q;
   assign core_rst_o     = core_rst_q;
   assign boot_pc_o      = boot_pc_q;
   assign done_o         = done_q;
   assign error_o        = error_q;

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: directed streams into image_loader; expected TCM writes
// (address, data, cycle) are queued at accept time and checked by a
// separate write monitor. Follows LOADER_CHECKSUM_EN if defined.
module tb_image_loader;
   localparam int unsigned ADDR_W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_rst;
   logic        done;
   logic        error;
   logic [31:0] boot_pc;

   always #5 clk = ~clk;

   image_loader_if #(.ADDR_W(ADDR_W)) ifc ();

   image_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (ifc.slave),
      .core_rst_o (core_rst),
      .boot_pc_o  (boot_pc),
      .done_o     (done),
      .error_o    (error)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      int unsigned       due;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  pl_q[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   // Cycle stamp used to check write latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (ifc.wr_en_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                     ifc.wr_addr_o, ifc.wr_data_o);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(ifc.wr_addr_o), 32'(e.addr));
            check("wr_data", 32'(ifc.wr_data_o), 32'(e.data));
            check("wr_cycle", cyc, e.due);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      ifc.in_valid_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_ready", 32'(ifc.in_ready_o), 32'd0);
      check("rst_wr_en", 32'(ifc.wr_en_o), 32'd0);
      check("rst_wr_addr", 32'(ifc.wr_addr_o), 32'd0);
      check("rst_wr_data", 32'(ifc.wr_data_o), 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_boot_pc", boot_pc, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", 32'(ifc.in_ready_o), 32'd1);
   endtask

   // Present one byte until accepted; returns the accept cycle stamp.
   task automatic send_byte(input logic [7:0] b, output int unsigned acc);
      int n = 0;
      ifc.in_valid_i = 1'b1;
      ifc.in_data_i  = b;
      while (ifc.in_ready_o !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got in_ready_o=0 for 50 cycles, expected 1");
      end
      @(posedge clk); #1;
      acc = cyc;
      ifc.in_valid_i = 1'b0;
      ifc.in_data_i  = 8'hA5;
   endtask

   task automatic gap(input bit gapped);
      if (gapped) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gapped);
      int unsigned c;
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8], c);
         gap(gapped);
      end
   endtask

   // Full stream from pl_q; checksum byte (sum + ck_delta) only when compiled in.
   task automatic run_stream(input logic [31:0] pc, input logic [31:0] n,
                             input bit gapped, input logic [7:0] ck_delta);
      int unsigned c;
      logic [7:0]  s = 8'd0;
      send_word(pc, gapped);
      send_word(n, gapped);
      for (int i = 0; i < pl_q.size(); i++) begin
         send_byte(pl_q[i], c);
         exp_q.push_back('{addr: ADDR_W'(i), data: pl_q[i], due: c});
         s = s + pl_q[i];
         if (i != pl_q.size() - 1) gap(gapped);
      end
`ifdef LOADER_CHECKSUM_EN
      gap(gapped && pl_q.size() != 0);
      send_byte(s + ck_delta, c);
`else
      s = s + ck_delta;
`endif
   endtask

   // Called just after the final accepting edge.
   task automatic expect_done(input string tag, input logic [31:0] pc);
      check({tag, "_ready_low"}, 32'(ifc.in_ready_o), 32'd0);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      check({tag, "_core_rst_early"}, 32'(core_rst), 32'd1);
      @(posedge clk); #1;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_boot_pc"}, boot_pc, pc);
      check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
      // Bytes offered after completion must be ignored.
      ifc.in_valid_i = 1'b1;
      ifc.in_data_i  = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      ifc.in_valid_i = 1'b0;
      check({tag, "_done_hold"}, 32'(done), 32'd1);
      check({tag, "_pc_hold"}, boot_pc, pc);
   endtask

   task automatic expect_error(input string tag);
      @(posedge clk); #1;
      check({tag, "_error"}, 32'(error), 32'd1);
      check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_ready"}, 32'(ifc.in_ready_o), 32'd0);
      ifc.in_valid_i = 1'b1;
      ifc.in_data_i  = 8'h11;
      repeat (3) @(posedge clk);
      #1;
      ifc.in_valid_i = 1'b0;
      check({tag, "_error_hold"}, 32'(error), 32'd1);
      check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int unsigned c;
      ifc.in_valid_i = 1'b0;
      ifc.in_data_i  = 8'h00;

      // Basic load, back-to-back bytes.
      do_reset();
      pl_q = '{8'h13, 8'h00, 8'h00, 8'h00};
      run_stream(32'h0000_0200, 32'd4, 1'b0, 8'd0);
      expect_done("basic", 32'h0000_0200);

      // Same stream with valid toggling every other cycle.
      do_reset();
      run_stream(32'h0000_0200, 32'd4, 1'b1, 8'd0);
      expect_done("gapped", 32'h0000_0200);

      // Zero length: no writes.
      do_reset();
      pl_q.delete();
      run_stream(32'h0000_0000, 32'd0, 1'b0, 8'd0);
      expect_done("zero", 32'h0000_0000);

      // Oversize length aborts after the header.
      do_reset();
      send_word(32'h1234_5678, 1'b0);
      send_word(32'h0001_0001, 1'b0);
      expect_error("oversize");

      // Maximum length 2^ADDR_W: last write at 0xFFFF, no wrap.
      do_reset();
      pl_q.delete();
      for (int i = 0; i < 65536; i++) pl_q.push_back(8'(i * 7 + 3));
      run_stream(32'h8000_0000, 32'h0001_0000, 1'b0, 8'd0);
      expect_done("maxlen", 32'h8000_0000);

`ifdef LOADER_CHECKSUM_EN
      do_reset();
      pl_q = '{8'h01, 8'h02, 8'h03};
      run_stream(32'h0000_0040, 32'd3, 1'b0, 8'd0);
      expect_done("cksum_ok", 32'h0000_0040);

      do_reset();
      run_stream(32'h0000_0040, 32'd3, 1'b0, 8'd1);
      expect_error("cksum_bad");
`endif

      // Mid-load reset after payload byte 2 of 4, then a full new stream.
      do_reset();
      send_word(32'h0000_0100, 1'b0);
      send_word(32'd4, 1'b0);
      send_byte(8'hAA, c);
      exp_q.push_back('{addr: ADDR_W'(0), data: 8'hAA, due: c});
      send_byte(8'hBB, c);
      exp_q.push_back('{addr: ADDR_W'(1), data: 8'hBB, due: c});
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_core_rst", 32'(core_rst), 32'd1);
      check("midrst_ready", 32'(ifc.in_ready_o), 32'd0);
      check("midrst_boot_pc", boot_pc, 32'd0);
      check("midrst_wr_en", 32'(ifc.wr_en_o), 32'd0);
      check("midrst_pending", exp_q.size(), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_ready_again", 32'(ifc.in_ready_o), 32'd1);
      pl_q = '{8'h93, 8'h05, 8'h10, 8'h00};
      run_stream(32'h0000_0300, 32'd4, 1'b0, 8'd0);
      expect_done("midrst", 32'h0000_0300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
